uart_alu_packet_parser: RTL and testbench

Downstream consumer of the UART receiver's byte stream (`rx_valid`/`rx_data`). It parses framed ALU command packets and assembles the payload into 32-bit little-endian operands. It presents those operands to the ALU datapath over a valid/ready handshake, with opcode and first/last framing. Malformed packets are flagged and drained so the byte stream stays frame-aligned.

---
 rtl/uart_alu_pkg.sv | 36 +++
 rtl/uart_alu_packet_parser_if.sv | 23 ++
 rtl/uart_alu_packet_parser_byte_word_packer.sv | 33 +++
 rtl/uart_alu_packet_parser.sv | 107 ++++++++++
 tb/tb_uart_alu_packet_parser.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_alu_pkg.sv
// Packet format constants, opcode/state enums and the header legality rule
// shared by the ALU command parser.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        ALU_ECHO = 8'hEC,
        ALU_ADD  = 8'h10,
        ALU_MUL  = 8'h11,
        ALU_DIV  = 8'h12
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_DRAIN
    } parse_state_e;

    localparam logic [15:0] HDR_BYTES     = 16'd4;
    localparam logic [15:0] MIN_LEN_ECHO  = 16'd8;
    localparam logic [15:0] MIN_LEN_ARITH = 16'd12;

    // Length counts the header too, so arithmetic ops need two whole operands.
    function automatic logic header_ok(input logic [7:0] op, input logic [15:0] len);
        logic min_ok;
        case (op)
            ALU_ECHO:                  min_ok = (len >= MIN_LEN_ECHO);
            ALU_ADD, ALU_MUL, ALU_DIV: min_ok = (len >= MIN_LEN_ARITH);
            default:                   min_ok = 1'b0;
        endcase
        return min_ok && (len[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/uart_alu_packet_parser_if.sv
// Byte-stream input and operand valid/ready output of the packet parser.
// The master side is the parser; the slave side feeds bytes and accepts words.
interface uart_alu_packet_parser_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic [7:0]  op_o;
    logic [31:0] operand_o;
    logic        operand_valid_o;
    logic        operand_ready_i;
    logic        first_o;
    logic        last_o;
    logic        err_o;

    modport master (
        input  rx_valid_i, rx_data_i, operand_ready_i,
        output op_o, operand_o, operand_valid_o, first_o, last_o, err_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, operand_ready_i,
        input  op_o, operand_o, operand_valid_o, first_o, last_o, err_o
    );
endinterface

// File: rtl/uart_alu_packet_parser_byte_word_packer.sv
// Little-endian 4-byte packer: the first three bytes shift into a holding
// register and the fourth byte completes the word combinationally.
module byte_word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        strobe,
    input  logic        clear,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        complete
);
    logic [1:0]  lane;
    logic [23:0] low_bytes;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane      <= 2'd0;
            low_bytes <= 24'd0;
        end else if (clear) begin
            lane <= 2'd0;
        end else if (strobe) begin
            lane      <= lane + 2'd1;
            low_bytes <= {data, low_bytes[23:8]};
        end
    end

    // The newest byte lands in the top lane, so the word is ready on the 4th strobe.
    assign complete = strobe && (lane == 2'd3);
    assign word     = {data, low_bytes};

endmodule

// File: rtl/uart_alu_packet_parser.sv
// Parses framed ALU command packets from the UART byte stream and presents the
// payload as 32-bit operands over a single-entry valid/ready holding register.
module uart_alu_packet_parser
    import uart_alu_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    uart_alu_packet_parser_if.master  bus
);
    parse_state_e state;
    logic [15:0]  remaining;
    logic [7:0]   len_lo;
    logic         first_pending;

    logic [31:0]  packed_word;
    logic         word_done;
    logic         pack_strobe;
    logic         pack_clear;
    logic [15:0]  len_full;
    logic         handshake;
    logic         can_load;

    assign pack_strobe = bus.rx_valid_i && (state == ST_PAYLOAD);
    assign pack_clear  = bus.rx_valid_i && (state == ST_LEN_HI);
    assign len_full    = {bus.rx_data_i, len_lo};
    assign handshake   = bus.operand_valid_o && bus.operand_ready_i;
    // An accept in the same cycle frees the register for the incoming word.
    assign can_load    = !bus.operand_valid_o || bus.operand_ready_i;

    byte_word_packer u_packer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .strobe   (pack_strobe),
        .clear    (pack_clear),
        .data     (bus.rx_data_i),
        .word     (packed_word),
        .complete (word_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= ST_IDLE;
            remaining           <= 16'd0;
            len_lo              <= 8'd0;
            first_pending       <= 1'b0;
            bus.op_o            <= 8'd0;
            bus.operand_o       <= 32'd0;
            bus.operand_valid_o <= 1'b0;
            bus.first_o         <= 1'b0;
            bus.last_o          <= 1'b0;
            bus.err_o           <= 1'b0;
        end else begin
            bus.err_o <= 1'b0;
            if (handshake)
                bus.operand_valid_o <= 1'b0;

            if (word_done) begin
                if (can_load) begin
                    bus.operand_o       <= packed_word;
                    bus.operand_valid_o <= 1'b1;
                    bus.first_o         <= first_pending;
                    bus.last_o          <= (remaining == 16'd1);
                end else begin
                    bus.err_o <= 1'b1;
                end
                first_pending <= 1'b0;
            end

            if (bus.rx_valid_i) begin
                case (state)
                    ST_IDLE: begin
                        bus.op_o <= bus.rx_data_i;
                        state    <= ST_HDR1;
                    end
                    ST_HDR1:   state <= ST_LEN_LO;
                    ST_LEN_LO: begin
                        len_lo <= bus.rx_data_i;
                        state  <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        if (header_ok(bus.op_o, len_full)) begin
                            remaining     <= len_full - HDR_BYTES;
                            first_pending <= 1'b1;
                            state         <= ST_PAYLOAD;
                        end else begin
                            bus.err_o <= 1'b1;
                            if (len_full <= HDR_BYTES) begin
                                remaining <= 16'd0;
                                state     <= ST_IDLE;
                            end else begin
                                remaining <= len_full - HDR_BYTES;
                                state     <= ST_DRAIN;
                            end
                        end
                    end
                    ST_PAYLOAD, ST_DRAIN: begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_packet_parser.sv
// Self-checking bench: directed packets plus randomized packets and ready
// patterns, compared every cycle against a packet-level reference model.
module tb_uart_alu_packet_parser;
    import uart_alu_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_alu_packet_parser_if bus ();

    uart_alu_packet_parser dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

    // Expected output state of the DUT.
    logic        m_valid, m_first, m_last, m_err;
    logic [31:0] m_word;
    logic [7:0]  m_op;

    // Events the current byte causes, computed from the packet contents.
    logic        ev_complete, ev_first, ev_last, ev_hdr_err, ev_op_load;
    logic [31:0] ev_word;
    logic [7:0]  ev_op;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0; m_err = 1'b0;
        m_word  = 32'd0; m_op = 8'd0;
    endtask

    task automatic clear_events();
        ev_complete = 1'b0; ev_first = 1'b0; ev_last = 1'b0;
        ev_hdr_err  = 1'b0; ev_op_load = 1'b0;
        ev_word     = 32'd0; ev_op = 8'd0;
    endtask

    // One clock: drive ready, update the model at the edge, compare #1 later.
    task automatic tick();
        logic was_valid;
        case (ready_mode)
            0:       bus.operand_ready_i = 1'b1;
            1:       bus.operand_ready_i = 1'($urandom_range(0, 1));
            default: bus.operand_ready_i = 1'b0;
        endcase
        @(posedge clk);
        was_valid = m_valid;
        m_err     = ev_hdr_err;
        if (m_valid && bus.operand_ready_i)
            m_valid = 1'b0;
        if (ev_complete) begin
            if (!was_valid || bus.operand_ready_i) begin
                m_valid = 1'b1;
                m_word  = ev_word;
                m_first = ev_first;
                m_last  = ev_last;
            end else begin
                m_err = 1'b1;
            end
        end
        if (ev_op_load)
            m_op = ev_op;
        #1;
        check("valid", 32'(bus.operand_valid_o), 32'(m_valid));
        check("err",   32'(bus.err_o),           32'(m_err));
        check("op",    32'(bus.op_o),            32'(m_op));
        if (m_valid) begin
            check("operand", bus.operand_o,       m_word);
            check("first",   32'(bus.first_o),    32'(m_first));
            check("last",    32'(bus.last_o),     32'(m_last));
        end
        bus.rx_valid_i = 1'b0;
        clear_events();
    endtask

    // Sends n_send bytes of pkt, one byte every other cycle.
    task automatic send_packet(input byte_q_t pkt, input int n_send);
        int   len;
        int   min_len;
        logic good;
        len = int'(pkt[3]) * 256 + int'(pkt[2]);
        case (pkt[0])
            8'hEC:               min_len = 8;
            8'h10, 8'h11, 8'h12: min_len = 12;
            default:             min_len = -1;
        endcase
        good = (min_len > 0) && (len >= min_len) && (len % 4 == 0);
        for (int i = 0; i < n_send; i++) begin
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = pkt[i];
            ev_op_load     = (i == 0);
            ev_op          = pkt[0];
            ev_hdr_err     = (i == 3) && !good;
            if (good && i >= 7 && (i % 4) == 3) begin
                ev_complete = 1'b1;
                ev_word     = {pkt[i], pkt[i-1], pkt[i-2], pkt[i-3]};
                ev_first    = (i == 7);
                ev_last     = (i == len - 1);
            end
            tick();
            tick();
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   32'(bus.operand_valid_o), 32'd0);
        check({tag, "_operand"}, bus.operand_o,            32'd0);
        check({tag, "_op"},      32'(bus.op_o),            32'd0);
        check({tag, "_first"},   32'(bus.first_o),         32'd0);
        check({tag, "_last"},    32'(bus.last_o),          32'd0);
        check({tag, "_err"},     32'(bus.err_o),           32'd0);
    endtask

    function automatic byte_q_t random_packet(output int n_send);
        byte_q_t p;
        logic [7:0] op;
        int len;
        case ($urandom_range(0, 4))
            0:       op = 8'hEC;
            1:       op = 8'h10;
            2:       op = 8'h11;
            3:       op = 8'h12;
            default: op = 8'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) len = int'($urandom_range(0, 40));
        else                           len = 4 * int'($urandom_range(2, 8));
        n_send = (len > 4) ? len : 4;
        p.push_back(op);
        p.push_back(8'($urandom));
        p.push_back(8'(len));
        p.push_back(8'(len >> 8));
        for (int k = 4; k < n_send; k++)
            p.push_back(8'($urandom));
        return p;
    endfunction

    initial begin
        byte_q_t p;
        int      n;

        rst = 1'b1;
        bus.rx_valid_i      = 1'b0;
        bus.rx_data_i       = 8'd0;
        bus.operand_ready_i = 1'b1;
        model_reset();
        clear_events();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // ADD with two operands, always ready.
        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00};
        send_packet(p, 12);
        idle(2);

        // ECHO length 8.
        p = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_packet(p, 8);
        idle(2);

        // Illegal opcode is drained, then a good ADD follows.
        p = '{8'h55, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_packet(p, 8);
        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hCD, 8'hAB, 8'h89};
        send_packet(p, 12);
        idle(2);

        // Length not a multiple of 4: six payload bytes drained.
        p = '{8'h10, 8'h00, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_packet(p, 10);
        p = '{8'h11, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
              8'h04, 8'h00, 8'h00, 8'h00};
        send_packet(p, 12);
        idle(2);

        // Ready low across two words: first held, second dropped with err.
        ready_mode = 2;
        p = '{8'h12, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11,
              8'h22, 8'h22, 8'h22, 8'h22};
        send_packet(p, 12);
        idle(3);
        ready_mode = 0;
        idle(4);

        // Asynchronous reset in the middle of the payload.
        p = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h09, 8'h08, 8'h07, 8'h06,
              8'h05, 8'h04, 8'h03, 8'h02};
        send_packet(p, 10);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        send_packet(p, 12);
        idle(2);

        // Randomized packets with random ready.
        ready_mode = 1;
        for (int t = 0; t < 60; t++) begin
            p = random_packet(n);
            send_packet(p, n);
            idle(int'($urandom_range(0, 3)));
        end
        ready_mode = 0;
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
